// File: rtl/outerprodrc_seq.sv
// outerprodrc_seq: job sequencer for the rate-coded outer-product array.
// A job of len (row,col) pairs is accepted over a valid/ready stream. The
// array is cleared once, each pair is applied with the enable high for one
// unary period, and the accumulated array output is returned on a
// valid/ready result port. A one-entry prefetch buffer keeps consecutive
// pairs running back-to-back.
module outerprodrc_seq #(
  parameter int ROWNUM      = 2,
  parameter int COLNUM      = 2,
  parameter int BITWIDTH    = 4,
  parameter int OUTBITWIDTH = 8,
  parameter int LENW        = 8
) (
  input  logic                                 iClk,
  input  logic                                 iRst,
  input  logic                                 iStart,
  input  logic [LENW-1:0]                      iLen,
  input  logic                                 iVecValid,
  output logic                                 oVecReady,
  input  logic [ROWNUM*BITWIDTH-1:0]           iVecData0,
  input  logic [COLNUM*BITWIDTH-1:0]           iVecData1,
  output logic                                 oArrEn,
  output logic                                 oArrClr,
  output logic [ROWNUM*BITWIDTH-1:0]           oArrData0,
  output logic [COLNUM*BITWIDTH-1:0]           oArrData1,
  input  logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0] iArrData,
  output logic                                 oResValid,
  input  logic                                 iResReady,
  output logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0] oResData,
  output logic                                 oBusy
);

  localparam int PERIOD = 2 ** (BITWIDTH - 1);
  localparam int CW     = (BITWIDTH > 1) ? (BITWIDTH - 1) : 1;
  localparam int RW     = ROWNUM * BITWIDTH;
  localparam int CLW    = COLNUM * BITWIDTH;
  localparam int AW     = ROWNUM * COLNUM * OUTBITWIDTH;
  localparam logic [CW-1:0] CCNT_LAST = CW'(PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LENW-1:0]  len_q, len_d;
  logic [LENW-1:0]  pcnt_q, pcnt_d;     // pairs whose period has completed
  logic [LENW-1:0]  acc_q, acc_d;       // pairs accepted from the stream
  logic [CW-1:0]    ccnt_q, ccnt_d;     // cycle within the current period
  logic             buf_full_q, buf_full_d;
  logic [RW-1:0]    buf0_q, buf0_d;
  logic [CLW-1:0]   buf1_q, buf1_d;
  logic [RW-1:0]    arr0_q, arr0_d;
  logic [CLW-1:0]   arr1_q, arr1_d;
  logic [AW-1:0]    res_q, res_d;
  logic             arr_en_q, arr_en_d;
  logic             arr_clr_q, arr_clr_d;
  logic             res_valid_q, res_valid_d;
  logic             vec_ready_q, vec_ready_d;
  logic             busy_q, busy_d;
  logic             hs;
  logic             last_pair;

  assign oVecReady = vec_ready_q;
  assign oArrEn    = arr_en_q;
  assign oArrClr   = arr_clr_q;
  assign oArrData0 = arr0_q;
  assign oArrData1 = arr1_q;
  assign oResValid = res_valid_q;
  assign oResData  = res_q;
  assign oBusy     = busy_q;

  // Next-state, datapath and registered-output decode for the sequencer.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    pcnt_d     = pcnt_q;
    acc_d      = acc_q;
    ccnt_d     = ccnt_q;
    buf_full_d = buf_full_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    arr0_d     = arr0_q;
    arr1_d     = arr1_q;
    res_d      = res_q;
    // Ready is only ever high with the buffer empty, so a handshake and a
    // buffer drain can never collide in the same cycle.
    hs         = iVecValid & vec_ready_q;
    last_pair  = ((pcnt_q + LENW'(1)) == len_q);

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          len_d   = iLen;
          pcnt_d  = '0;
          acc_d   = '0;
          state_d = S_CLR;
        end
      end

      S_CLR: begin
        state_d = (len_q == '0) ? S_DRAIN : S_LOAD;
      end

      S_LOAD: begin
        if (buf_full_q) begin
          arr0_d     = buf0_q;
          arr1_d     = buf1_q;
          buf_full_d = 1'b0;
          ccnt_d     = '0;
          state_d    = S_RUN;
        end else if (hs) begin
          // First pair of a stall goes straight to the array registers.
          arr0_d  = iVecData0;
          arr1_d  = iVecData1;
          acc_d   = acc_q + LENW'(1);
          ccnt_d  = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (hs) begin
          buf0_d     = iVecData0;
          buf1_d     = iVecData1;
          buf_full_d = 1'b1;
          acc_d      = acc_q + LENW'(1);
        end
        if (ccnt_q == CCNT_LAST) begin
          pcnt_d = pcnt_q + LENW'(1);
          ccnt_d = '0;
          if (last_pair) begin
            state_d = S_DRAIN;
          end else if (buf_full_q) begin
            // Prefetched pair takes over with no idle cycle.
            arr0_d     = buf0_q;
            arr1_d     = buf1_q;
            buf_full_d = 1'b0;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          ccnt_d = ccnt_q + CW'(1);
        end
      end

      S_DRAIN: begin
        // Enable is low this cycle, so the array output has settled.
        res_d   = iArrData;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (iResReady) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    arr_en_d    = (state_d == S_RUN);
    arr_clr_d   = (state_d == S_CLR);
    res_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    vec_ready_d = ((state_d == S_LOAD) || (state_d == S_RUN)) &&
                  !buf_full_d && (acc_d < len_d);
  end

  // State, counters, buffer and registered outputs; reset clears everything.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      pcnt_q      <= '0;
      acc_q       <= '0;
      ccnt_q      <= '0;
      buf_full_q  <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      arr0_q      <= '0;
      arr1_q      <= '0;
      res_q       <= '0;
      arr_en_q    <= 1'b0;
      arr_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      vec_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      pcnt_q      <= pcnt_d;
      acc_q       <= acc_d;
      ccnt_q      <= ccnt_d;
      buf_full_q  <= buf_full_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      arr0_q      <= arr0_d;
      arr1_q      <= arr1_d;
      res_q       <= res_d;
      arr_en_q    <= arr_en_d;
      arr_clr_q   <= arr_clr_d;
      res_valid_q <= res_valid_d;
      vec_ready_q <= vec_ready_d;
      busy_q      <= busy_d;
    end
  end

endmodule
